vga_capture: RTL and testbench

- VGA sink: the receiving end of the display timing interface (hsync, vsync, valid, 24-bit RGB).
- Reconstructs pixel coordinates from the sync and valid strobes.
- Writes each active pixel into a frame memory at address {x[9:0], y[8:0]}. This is the same 19-bit packing the display-side vmem uses, so a captured frame can be replayed unchanged.
- Used as a loopback checker for the VGA controller and as a frame grabber.

---
 rtl/vga_capture.sv | 123 ++++++++++++
 tb/tb_vga_capture.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// vga_capture: VGA sink that rebuilds pixel coordinates and writes active pixels to frame memory at {x,y}.
// Define VGA_CAPTURE_SUM_EN to enable the frame_sum checksum accumulator.
module vga_capture #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter bit SYNC_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        continuous,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        mem_we,
  output logic [18:0] mem_addr,
  output logic [23:0] mem_wdata,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow,
  output logic [31:0] frame_sum
);
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DONE} state_t;
  localparam logic [9:0] HMAX = 10'(H_ACTIVE);
  localparam logic [9:0] VMAX = 10'(V_ACTIVE);
  state_t state_q, state_d;
  logic hs_q, vs_q, val_q, vs_d1_q, val_d1_q;
  logic [23:0] rgb_q;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic we_q, we_d, ovf_q, ovf_d, done_q, done_d;
  logic [18:0] addr_q, addr_d;
  logic [23:0] wdata_q, wdata_d;
  logic vs_rise, val_fall, cap, in_rng, start, restart;
  assign vs_rise  = vs_q & ~vs_d1_q;
  assign val_fall = ~val_q & val_d1_q;
  assign cap      = state_q == CAPTURE;
  assign start    = state_q == WAIT_FRAME && arm && vs_rise;
  assign restart  = cap && arm && vs_rise && continuous;
  assign in_rng   = x_q < HMAX && y_q < VMAX;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      val_q    <= 1'b0;
      vs_d1_q  <= 1'b0;
      val_d1_q <= 1'b0;
      rgb_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hs_q     <= SYNC_ACTIVE_LOW ? ~hsync : hsync;
      vs_q     <= SYNC_ACTIVE_LOW ? ~vsync : vsync;
      val_q    <= valid;
      vs_d1_q  <= vs_q;
      val_d1_q <= val_q;
      rgb_q    <= {vga_r, vga_g, vga_b};
      x_q      <= x_d;
      y_q      <= y_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = arm ? WAIT_FRAME : IDLE;
      WAIT_FRAME: state_d = !arm ? IDLE : vs_rise ? CAPTURE : WAIT_FRAME;
      CAPTURE:    state_d = !arm ? IDLE : (vs_rise && !continuous) ? DONE : CAPTURE;
      DONE:       state_d = arm ? DONE : IDLE;
      default:    state_d = IDLE;
    endcase
  end
  // Writes keep issuing from the CAPTURE cycle even if arm just dropped, so the last sampled pixel lands.
  always_comb begin
    we_d    = cap && val_q && in_rng;
    addr_d  = we_d ? {x_q, y_q[8:0]} : addr_q;
    wdata_d = we_d ? rgb_q : wdata_q;
    x_d     = we_d ? x_q + 10'd1 : x_q;
    y_d     = y_q;
    if (cap && val_fall) begin
      x_d = '0;
      y_d = y_q < VMAX ? y_q + 10'd1 : y_q;
    end
    if (start || restart) begin
      x_d = '0;
      y_d = '0;
    end
    ovf_d  = start ? 1'b0 : ovf_q | (cap && val_q && (!in_rng || hs_q));
    done_d = cap && arm && vs_rise;
  end
  always_comb begin
    busy       = state_q == WAIT_FRAME || state_q == CAPTURE;
    mem_we     = we_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    overflow   = ovf_q;
    frame_done = done_q;
  end
`ifdef VGA_CAPTURE_SUM_EN
  logic [31:0] sum_q, sum_d;
  always_comb sum_d = (start || restart) ? '0 : we_q ? sum_q + {8'h0, wdata_q} : sum_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sum_q <= '0;
    else      sum_q <= sum_d;
  end
  assign frame_sum = sum_q;
`else
  assign frame_sum = '0;
`endif
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: randomized frames against a line/pixel-level write-list model of vga_capture.
module tb_vga_capture;
  localparam int H = 4;
  localparam int V = 3;
`ifdef VGA_CAPTURE_SUM_EN
  localparam bit SUM = 1;
`else
  localparam bit SUM = 0;
`endif
  logic clk = 0, rst, arm, continuous, hsync, vsync, valid;
  logic [7:0] vga_r, vga_g, vga_b;
  logic mem_we, busy, frame_done, overflow;
  logic [18:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [31:0] frame_sum;
  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .arm(arm), .continuous(continuous), .hsync(hsync), .vsync(vsync),
    .valid(valid), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .frame_done(frame_done),
    .overflow(overflow), .frame_sum(frame_sum)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0, done_cnt = 0;
  logic [42:0] exp_q[$], got_q[$];
  logic [31:0] exp_sum;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (mem_we) got_q.push_back({mem_addr, mem_wdata});
    if (frame_done) done_cnt++;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic vs_pulse;
    vsync = 0; tick; tick;
    vsync = 1; tick; tick;
  endtask
  // A line of n pixels; only pixels inside the active window are expected in memory.
  task automatic send_line(input int l, input int n, input bit idx);
    logic [23:0] d;
    for (int p = 0; p < n; p++) begin
      d = idx ? 24'(l * H + p) : 24'($urandom);
      valid = 1;
      {vga_r, vga_g, vga_b} = d;
      if (l < V && p < H) begin
        exp_q.push_back({10'(p), 9'(l), d});
        exp_sum += {8'h0, d};
      end
      tick;
    end
    valid = 0; tick;
    hsync = 0; tick;
    hsync = 1; tick;
  endtask
  task automatic check_writes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 0; arm = 0; continuous = 0; hsync = 1; vsync = 1; valid = 0;
    {vga_r, vga_g, vga_b} = '0;
    tick; tick;
    check("rst_ctl", {mem_we, busy, frame_done, overflow}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_wdata, 0);
    check("rst_sum", frame_sum, 0);
    rst = 1; tick;
    arm = 1; tick; tick;
    check("wait_busy", busy, 1);
    exp_sum = 0;
    vs_pulse;
    for (int l = 0; l < V; l++) send_line(l, H, 1);
    vs_pulse;
    check_writes("f1");
    check("f1_done", done_cnt, 1);
    check("f1_busy", busy, 0);
    check("f1_ovf", overflow, 0);
    check("f1_sum", frame_sum, SUM ? 32'd66 : 32'd0);
    arm = 0; tick; tick;
    check("f1_idle", busy, 0);
    done_cnt = 0; arm = 1; tick;
    exp_sum = 0;
    vs_pulse;
    send_line(0, H, 0);
    send_line(1, H + 1, 0);
    send_line(2, H, 0);
    vs_pulse;
    check_writes("long_line");
    check("long_ovf", overflow, 1);
    check("long_done", done_cnt, 1);
    check("long_sum", frame_sum, SUM ? exp_sum : 32'd0);
    arm = 0; tick;
    check("ovf_idle_hold", overflow, 1);
    arm = 1; tick; tick;
    check("ovf_wait_hold", overflow, 1);
    vs_pulse;
    check("ovf_clear", overflow, 0);
    for (int l = 0; l < V + 1; l++) send_line(l, H, 0);
    vs_pulse;
    check_writes("extra_line");
    check("extra_ovf", overflow, 1);
    arm = 0; tick; tick;
    done_cnt = 0; continuous = 1; arm = 1; tick;
    vs_pulse;
    for (int l = 0; l < V; l++) send_line(l, H, 0);
    vs_pulse;
    check_writes("cont_f1");
    check("cont_busy", busy, 1);
    exp_sum = 0;
    for (int l = 0; l < V; l++) send_line(l, H, 0);
    continuous = 0;
    vs_pulse;
    check_writes("cont_f2");
    check("cont_done", done_cnt, 2);
    check("cont_sum", frame_sum, SUM ? exp_sum : 32'd0);
    check("cont_end_busy", busy, 0);
    arm = 0; tick; tick;
    done_cnt = 0; arm = 1; tick;
    vs_pulse;
    send_line(0, H, 0);
    begin
      logic [23:0] d;
      d = 24'($urandom);
      valid = 1; {vga_r, vga_g, vga_b} = d;
      exp_q.push_back({10'd0, 9'd1, d});
      tick;
      {vga_r, vga_g, vga_b} = 24'($urandom);
      arm = 0; tick;
      valid = 0; tick; tick; tick;
    end
    check_writes("abort");
    check("abort_done", done_cnt, 0);
    check("abort_busy", busy, 0);
    arm = 1; tick;
    vs_pulse;
    valid = 1; {vga_r, vga_g, vga_b} = 24'($urandom);
    tick; tick;
    #2 rst = 0;
    got_q.delete();
    #1;
    check("rst_mid_ctl", {mem_we, busy, frame_done, overflow}, 0);
    check("rst_mid_addr", mem_addr, 0);
    check("rst_mid_sum", frame_sum, 0);
    tick; tick;
    rst = 1;
    for (int i = 0; i < 6; i++) begin
      {vga_r, vga_g, vga_b} = 24'($urandom);
      tick;
    end
    valid = 0; tick;
    check("rst_no_we", got_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
